// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank.
//   state_e     : transfer FSM states (IDLE, ACCESS)
//   idx_shift() : byte-address to register-index shift for a data width
//   strb_merge(): byte-strobed merge of new write data into an old word
package apb_regbank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Register index = byte address >> log2(bytes per word).
    function automatic int unsigned idx_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Works at the maximum width (64 bits / 8 lanes); callers zero-extend
    // their operands and keep only the low DATA_W bits of the result.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] merged;
        for (int b = 0; b < 8; b++) begin
            merged[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB bus bundle between the interconnect (master) and the register bank (slave).
//   paddr/psel/penable/pwrite/pwdata/pstrb : master -> slave request
//   pready/pslverr/prdata                  : slave -> master response
interface apb_regbank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic                pslverr;
    logic [DATA_W-1:0]   prdata;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_regbank_cell.sv
// One read/write register of the bank with byte-strobed update.
//   pclk    : clock, rising edge
//   preset  : synchronous active-high reset, loads RESET_VAL
//   we_i    : commit write this cycle
//   strb_i  : byte lanes to update
//   wdata_i : write data
//   q_o     : current register value
module apb_regbank_cell
    import apb_regbank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] strb_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   q_o
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic [63:0]       merged;

    always_comb begin
        merged = strb_merge(64'(q_q), 64'(wdata_i), 8'(strb_i));
        q_d    = we_i ? merged[DATA_W-1:0] : q_q;
    end

    // NOTE: the register file is built from flops, not a RAM macro, so every
    // cell is reset; software relies on reading RESET_VAL after reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/apb_regbank.sv
// Parametrised APB slave register bank.
//   pclk    : clock, rising edge
//   preset  : synchronous active-high reset
//   bus     : APB slave port (apb_regbank_if.slave)
//   ro_in   : NUM_REGS*DATA_W hardware status; slice i read when RO_MASK[i]=1
//   reg_out : NUM_REGS*DATA_W RW register contents; read-only slices drive 0
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    apb_regbank_if.slave                 bus,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out
);

    localparam int          BYTES      = DATA_W / 8;
    localparam int          SHIFT      = idx_shift(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;

    // Request captured in the setup phase; the master may change its bus
    // signals once the setup cycle is over without affecting the transfer.
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BYTES-1:0]   strb_q;
    logic               err_q;

    logic [DATA_W-1:0]  cell_q [NUM_REGS];
    logic [NUM_REGS-1:0] we;

    logic [ADDR_W-1:0] dec_addr;
    logic              dec_write;
    logic [ADDR_W-1:0] dec_idx;
    logic              dec_hit;
    logic              dec_ro;
    logic [DATA_W-1:0] dec_val;
    logic              dec_err;
    logic [DATA_W-1:0] rd_val;
    logic              commit;

    // Decode the live bus during setup and the captured request afterwards,
    // so one decoder serves both the error check and the delayed read sample.
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_addr  = (state_q == IDLE) ? bus.paddr  : addr_q;
        dec_write = (state_q == IDLE) ? bus.pwrite : write_q;
        dec_idx   = dec_addr >> SHIFT;
        dec_hit   = 1'b0;
        dec_ro    = 1'b0;
        dec_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            // The full-width index compare also rejects set upper address bits.
            if (dec_idx == ADDR_W'(i)) begin
                dec_hit = 1'b1;
                dec_ro  = RO_MASK[i];
                dec_val = RO_MASK[i] ? ro_in[i*DATA_W +: DATA_W] : cell_q[i];
            end
        end
        dec_err = ((dec_addr & ALIGN_MASK) != '0) || !dec_hit || (dec_write && dec_ro);
        rd_val  = (!dec_err && !dec_write) ? dec_val : '0;
    end

    // Completion edge of a legal write.
    assign commit = (state_q == ACCESS) && pready_q && bus.psel && bus.penable
                    && write_q && !err_q;

    always_comb begin
        we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            we[i] = commit && (dec_idx == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            // Read-only slot: no storage, reads come from ro_in.
            assign cell_q[g] = '0;
        end else begin : g_rw
            apb_regbank_cell #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .pclk    (pclk),
                .preset  (preset),
                .we_i    (we[g]),
                .strb_i  (strb_q),
                .wdata_i (wdata_q),
                .q_o     (cell_q[g])
            );
        end
        assign reg_out[g*DATA_W +: DATA_W] = cell_q[g];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.psel && !bus.penable) begin
                        addr_q  <= bus.paddr;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        strb_q  <= bus.pstrb;
                        err_q   <= dec_err;
                        cnt_q   <= WS;
                        state_q <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            prdata_q  <= rd_val;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        // Master abort: drop the transfer without writing.
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (bus.penable) begin
                        if (pready_q) begin
                            state_q   <= IDLE;
                            pready_q  <= 1'b0;
                            pslverr_q <= 1'b0;
                            prdata_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= err_q;
                                prdata_q  <= rd_val;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Directed testbench for apb_regbank. Three instances share one set of bus
// drivers; `sel` routes psel/penable to one instance and picks its response.
//   u0: WAIT_STATES=0, RO_MASK=8'h80, RESET_VAL=0
//   u3: WAIT_STATES=3, RESET_VAL=32'h0BAD_F00D
//   u2: WAIT_STATES=2, RESET_VAL=0
module tb_apb_regbank;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  sel;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [255:0] ro0;
    logic [255:0] ro_zero;
    logic [255:0] reg_out0;
    logic [255:0] reg_out3;
    logic [255:0] reg_out2;

    logic        pready_m;
    logic        pslverr_m;
    logic [31:0] prdata_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    apb_regbank_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
    apb_regbank_if #(.DATA_W(32), .ADDR_W(32)) if3 ();
    apb_regbank_if #(.DATA_W(32), .ADDR_W(32)) if2 ();

    assign if0.paddr   = paddr;
    assign if0.pwrite  = pwrite;
    assign if0.pwdata  = pwdata;
    assign if0.pstrb   = pstrb;
    assign if0.psel    = psel    && (sel == 2'd0);
    assign if0.penable = penable && (sel == 2'd0);
    assign if3.paddr   = paddr;
    assign if3.pwrite  = pwrite;
    assign if3.pwdata  = pwdata;
    assign if3.pstrb   = pstrb;
    assign if3.psel    = psel    && (sel == 2'd1);
    assign if3.penable = penable && (sel == 2'd1);
    assign if2.paddr   = paddr;
    assign if2.pwrite  = pwrite;
    assign if2.pwdata  = pwdata;
    assign if2.pstrb   = pstrb;
    assign if2.psel    = psel    && (sel == 2'd2);
    assign if2.penable = penable && (sel == 2'd2);

    assign pready_m  = (sel == 2'd0) ? if0.pready  : (sel == 2'd1) ? if3.pready  : if2.pready;
    assign pslverr_m = (sel == 2'd0) ? if0.pslverr : (sel == 2'd1) ? if3.pslverr : if2.pslverr;
    assign prdata_m  = (sel == 2'd0) ? if0.prdata  : (sel == 2'd1) ? if3.prdata  : if2.prdata;

    apb_regbank #(
        .DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_STATES(0),
        .RO_MASK(8'h80), .RESET_VAL(32'h0)
    ) u0 (
        .pclk(pclk), .preset(preset), .bus(if0), .ro_in(ro0), .reg_out(reg_out0)
    );

    apb_regbank #(
        .DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_STATES(3),
        .RO_MASK(8'h00), .RESET_VAL(32'h0BAD_F00D)
    ) u3 (
        .pclk(pclk), .preset(preset), .bus(if3), .ro_in(ro_zero), .reg_out(reg_out3)
    );

    apb_regbank #(
        .DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .WAIT_STATES(2),
        .RO_MASK(8'h00), .RESET_VAL(32'h0)
    ) u2 (
        .pclk(pclk), .preset(preset), .bus(if2), .ro_in(ro_zero), .reg_out(reg_out2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transfer. Returns in the negedge of the pready cycle so a
    // following call can place its setup in the very next cycle.
    task automatic apb_xfer(input logic [1:0] s, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int lat);
        @(negedge pclk);
        check("pready_low_before_setup", 32'(pready_m), 32'(0));
        sel     = s;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        @(negedge pclk);
        penable = 1'b1;
        lat     = 1;
        while (!pready_m && lat < 40) begin
            @(negedge pclk);
            lat++;
        end
        check("pready_seen", 32'(pready_m), 32'(1));
        rdata = prdata_m;
        err   = pslverr_m;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        check("pready_one_cycle", 32'(pready_m), 32'(0));
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;

        preset  = 1'b1;
        sel     = 2'd0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        ro_zero = '0;
        ro0     = '0;
        ro0[7*32 +: 32] = 32'h5A5A_5A5A;
        ro0[1*32 +: 32] = 32'hDEAD_BEEF;  // must never appear on an RW slot
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // Reset state
        check("rst_pready_u0",  32'(if0.pready),  32'(0));
        check("rst_pslverr_u0", 32'(if0.pslverr), 32'(0));
        check("rst_prdata_u0",  if0.prdata,       32'h0);
        check("rst_pready_u3",  32'(if3.pready),  32'(0));
        check("rst_regout0_s1", reg_out0[1*32 +: 32], 32'h0);
        check("rst_regout3_s5", reg_out3[5*32 +: 32], 32'h0BAD_F00D);

        // Full-word write then read, zero wait states
        apb_xfer(2'd0, 32'h4, 1'b1, 32'hCAFE_BABE, 4'hF, rd, er, lt);
        check("w4_err", 32'(er), 32'(0));
        check("w4_lat", 32'(lt), 32'(1));
        bus_idle();
        check("w4_regout_s1", reg_out0[1*32 +: 32], 32'hCAFE_BABE);
        apb_xfer(2'd0, 32'h4, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r4_data", rd, 32'hCAFE_BABE);
        check("r4_err",  32'(er), 32'(0));
        check("r4_lat",  32'(lt), 32'(1));

        // Byte-strobed merge, back-to-back with read-after-write
        apb_xfer(2'd0, 32'h8, 1'b1, 32'h1122_3344, 4'hF, rd, er, lt);
        apb_xfer(2'd0, 32'h8, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, lt);
        apb_xfer(2'd0, 32'h8, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r8_strb_merge", rd, 32'h11BB_33DD);
        // pstrb=0 is a legal no-op
        apb_xfer(2'd0, 32'h8, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, lt);
        check("w8_nostrb_err", 32'(er), 32'(0));
        apb_xfer(2'd0, 32'h8, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r8_after_nostrb", rd, 32'h11BB_33DD);

        // Error responses
        apb_xfer(2'd0, 32'h40, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r40_err",  32'(er), 32'(1));
        check("r40_data", rd, 32'h0);
        apb_xfer(2'd0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("rhigh_err",  32'(er), 32'(1));
        check("rhigh_data", rd, 32'h0);
        apb_xfer(2'd0, 32'h6, 1'b1, 32'h1234_5678, 4'hF, rd, er, lt);
        check("w6_misalign_err", 32'(er), 32'(1));
        check("w6_data", rd, 32'h0);
        apb_xfer(2'd0, 32'h1C, 1'b1, 32'h1234_5678, 4'hF, rd, er, lt);
        check("w1c_ro_err", 32'(er), 32'(1));
        check("w1c_data", rd, 32'h0);
        bus_idle();
        check("err_regout_s1", reg_out0[1*32 +: 32], 32'hCAFE_BABE);
        check("err_regout_s2", reg_out0[2*32 +: 32], 32'h11BB_33DD);
        check("err_regout_s7", reg_out0[7*32 +: 32], 32'h0);
        // Read-only slot returns ro_in
        apb_xfer(2'd0, 32'h1C, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r1c_ro_data", rd, 32'h5A5A_5A5A);
        check("r1c_ro_err",  32'(er), 32'(0));
        // Last RW slot is in range
        apb_xfer(2'd0, 32'h18, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("r18_err",  32'(er), 32'(0));
        check("r18_data", rd, 32'h0);
        bus_idle();

        // Three wait states: latency 4, back-to-back keeps latency
        apb_xfer(2'd1, 32'h0, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("ws3_r0_lat",  32'(lt), 32'(4));
        check("ws3_r0_data", rd, 32'h0BAD_F00D);
        apb_xfer(2'd1, 32'h4, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("ws3_r4_lat",  32'(lt), 32'(4));
        check("ws3_r4_data", rd, 32'h0BAD_F00D);
        bus_idle();

        // Reset in the middle of a write's wait phase
        @(negedge pclk);
        sel = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hC; pwdata = 32'h55AA_55AA; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("rst_mid_wait_pready", 32'(pready_m), 32'(0));
        preset = 1'b1;
        @(negedge pclk);
        check("rst_mid_pready",  32'(pready_m),  32'(0));
        check("rst_mid_pslverr", 32'(pslverr_m), 32'(0));
        check("rst_mid_prdata",  prdata_m, 32'h0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        apb_xfer(2'd1, 32'hC, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("rst_mid_rC", rd, 32'h0BAD_F00D);
        bus_idle();
        check("rst_mid_regout_s3", reg_out3[3*32 +: 32], 32'h0BAD_F00D);

        // Two wait states: a normal write, then a master abort
        apb_xfer(2'd2, 32'h14, 1'b1, 32'h0F0F_0F0F, 4'hF, rd, er, lt);
        check("ws2_w14_lat", 32'(lt), 32'(3));
        bus_idle();
        check("ws2_regout_s5", reg_out2[5*32 +: 32], 32'h0F0F_0F0F);
        @(negedge pclk);
        sel = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("abort_wait_pready", 32'(pready_m), 32'(0));
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pready", 32'(pready_m), 32'(0));
        check("abort_regout_s4", reg_out2[4*32 +: 32], 32'h0);
        apb_xfer(2'd2, 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lt);
        check("abort_r10_data", rd, 32'h0);
        check("abort_r10_lat",  32'(lt), 32'(3));
        bus_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB slave register bank: NUM_REGS word-aligned registers, byte-strobed writes, per-register read-only masking, configurable wait states, and PSLVERR on illegal accesses. Next generation of the team's fixed four-register APB slave. Sits behind the APB interconnect. Exports every writable register as a flat bus to core logic and samples hardware status into read-only slots.

## Interface
- DATA_W, 32: data width; multiple of 8, max 64.
- ADDR_W, 32: paddr width.
- NUM_REGS, 8: register count, 1..64; register i at byte address i*(DATA_W/8).
- WAIT_STATES, 0: extra access-phase cycles before pready, 0..15.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only.
- RESET_VAL, 0: DATA_W value loaded into every RW register on reset.

- pclk  in  1  clock, rising edge.
- preset  in  1  synchronous reset, active-high.
- paddr  in  ADDR_W  byte address.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  write byte strobes.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid while pready=1.
- prdata  out  DATA_W  read data, valid while pready=1.
- ro_in  in  NUM_REGS*DATA_W  read-only slot values; slice i read when RO_MASK[i]=1.
- reg_out  out  NUM_REGS*DATA_W  RW register contents; RO slices drive 0.

## Operation
- FSM states: IDLE, ACCESS. Reset: IDLE; pready=0, pslverr=0, prdata=0, RW registers=RESET_VAL, wait counter=0.
- IDLE, psel=1 & penable=0 (setup): capture paddr/pwrite/pwdata/pstrb. Decode error = paddr not aligned to DATA_W/8, or index>=NUM_REGS, or pwrite=1 to RO register. Load counter=WAIT_STATES. Go to ACCESS. If WAIT_STATES=0, also assert pready. Set pslverr=error. Set prdata = selected value for a legal read, else 0.
- ACCESS, psel=1 & penable=1 & pready=0: decrement counter. When counter==1, assert pready, pslverr and prdata as above.
- ACCESS, psel=1 & penable=1 & pready=1 (completion edge): legal write updates bytes with pstrb[b]=1 from captured pwdata, other bytes kept. pstrb=0 is a legal no-op write. Clear pready, pslverr and prdata. Go to IDLE.
- ACCESS with psel=0 (master abort): no write. Clear outputs. Go to IDLE.
- Errors never modify state. Reads have no side effects.
- Register index = paddr >> log2(DATA_W/8). Upper paddr bits beyond the index are part of the range check.
- Reads return the current register value. For RO slots, ro_in is sampled at the edge that asserts pready.

## Timing
- WAIT_STATES=W: setup at cycle T; pready high during cycle T+1+W; completion edge ends that cycle.
- Back-to-back transfers: the next setup may be in the cycle right after completion; no idle cycle required.
- Write visible on reg_out the cycle after the completion edge.
- A read of a register in the transfer after a write to it returns the new value.
- pready is high for exactly one cycle per transfer. All outputs are registered.
- preset asserted mid-transfer: next cycle is IDLE with all outputs 0; the pending write is lost.

## Structure
- Package apb_regbank_pkg: state enum (IDLE, ACCESS); function computing the index shift from DATA_W; function for the byte-strobe merge.
- Sub-module apb_regbank_cell: one DATA_W register with RESET_VAL, write enable and byte strobes. Generated NUM_REGS times; RO slots tie it off.
- Top level holds the FSM, wait counter, decode and read mux.

## Test plan
- Defaults, reset, then write 0xCAFEBABE to 0x4 with pstrb=4'hF, then read 0x4 -> pready in access cycle 1, prdata=0xCAFEBABE, pslverr=0, reg_out slice 1 updated.
- Write 0x11223344 to 0x8, then write 0xAABBCCDD with pstrb=4'b0101 -> read 0x8 returns 0x11BB33DD.
- WAIT_STATES=3: read 0x0 -> pready first high in 4th access cycle, exactly one cycle; back-to-back second read completes with the same latency.
- Errors: read 0x40 (NUM_REGS=8), write 0x6 (misaligned), write to RO_MASK=8'h80 slot 0x1C -> pslverr=1, prdata=0, no register changes. Read 0x1C with ro_in slice 7=0x5A5A5A5A -> 0x5A5A5A5A, pslverr=0.
- Assert preset during the ACCESS wait of a write to 0xC -> pready=0 next cycle; read 0xC returns RESET_VAL.
- Drop psel mid-ACCESS with WAIT_STATES=2 -> FSM returns to IDLE; write not committed.
